// File: rtl/id_decode_stage_pkg.sv
// Shared decode definitions: opcode space, immediate formats and the decoded-entry layout.
package id_decode_stage_pkg;

  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_INVALID = 6'd0,
    OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA,
    OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_MOD, OP_DIVU, OP_MODU,
    OP_BREAK, OP_SYSCALL,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADDI, OP_SLTI, OP_SLTUI, OP_ANDI, OP_ORI, OP_XORI, OP_LDW, OP_STW,
    OP_LU12I, OP_PCADDU12I
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_SI12, IMM_UI12, IMM_UI5, IMM_UI20, IMM_CODE
  } imm_kind_e;

  typedef struct packed {
    op_e         op;
    logic        ine;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [4:0]  rk;
  } dec_t;

  function automatic logic is_muldiv(op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU) || (op == OP_DIV) ||
           (op == OP_MOD) || (op == OP_DIVU) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/id_decode_stage_decode_core.sv
// Pure combinational LA32R decode: opcode, extended immediate and not-exist flag.
module decode_core
  import id_decode_stage_pkg::*;
#(
  parameter int HAS_MULDIV = 1
) (
  input  logic [31:0] inst,
  output op_e         op,
  output logic [31:0] imm,
  output logic        ine
);

  op_e       raw;
  imm_kind_e kind;

  // The three opcode fields never overlap for the supported encodings.
  always_comb begin
    raw  = OP_INVALID;
    kind = IMM_NONE;
    case (inst[31:15])
      17'h00020: raw = OP_ADD;
      17'h00022: raw = OP_SUB;
      17'h00024: raw = OP_SLT;
      17'h00025: raw = OP_SLTU;
      17'h00028: raw = OP_NOR;
      17'h00029: raw = OP_AND;
      17'h0002A: raw = OP_OR;
      17'h0002B: raw = OP_XOR;
      17'h0002E: raw = OP_SLL;
      17'h0002F: raw = OP_SRL;
      17'h00030: raw = OP_SRA;
      17'h00038: raw = OP_MUL;
      17'h00039: raw = OP_MULH;
      17'h0003A: raw = OP_MULHU;
      17'h00040: raw = OP_DIV;
      17'h00041: raw = OP_MOD;
      17'h00042: raw = OP_DIVU;
      17'h00043: raw = OP_MODU;
      17'h00054: begin raw = OP_BREAK;   kind = IMM_CODE; end
      17'h00056: begin raw = OP_SYSCALL; kind = IMM_CODE; end
      17'h00081: begin raw = OP_SLLI;    kind = IMM_UI5;  end
      17'h00089: begin raw = OP_SRLI;    kind = IMM_UI5;  end
      17'h00091: begin raw = OP_SRAI;    kind = IMM_UI5;  end
      default: ;
    endcase
    case (inst[31:22])
      10'h008: begin raw = OP_SLTI;  kind = IMM_SI12; end
      10'h009: begin raw = OP_SLTUI; kind = IMM_SI12; end
      10'h00A: begin raw = OP_ADDI;  kind = IMM_SI12; end
      10'h00D: begin raw = OP_ANDI;  kind = IMM_UI12; end
      10'h00E: begin raw = OP_ORI;   kind = IMM_UI12; end
      10'h00F: begin raw = OP_XORI;  kind = IMM_UI12; end
      10'h0A2: begin raw = OP_LDW;   kind = IMM_SI12; end
      10'h0A6: begin raw = OP_STW;   kind = IMM_SI12; end
      default: ;
    endcase
    case (inst[31:25])
      7'h0A: begin raw = OP_LU12I;     kind = IMM_UI20; end
      7'h0E: begin raw = OP_PCADDU12I; kind = IMM_UI20; end
      default: ;
    endcase
  end

  always_comb begin
    op  = raw;
    ine = 1'b0;
    if (raw == OP_INVALID || (HAS_MULDIV == 0 && is_muldiv(raw))) begin
      op  = OP_INVALID;
      ine = 1'b1;
    end
    case (kind)
      IMM_SI12: imm = {{20{inst[21]}}, inst[21:10]};
      IMM_UI12: imm = {20'b0, inst[21:10]};
      IMM_UI5:  imm = {27'b0, inst[14:10]};
      IMM_UI20: imm = {inst[24:5], 12'b0};
      IMM_CODE: imm = {17'b0, inst[14:0]};
      default:  imm = 32'b0;
    endcase
    if (ine) imm = 32'b0;
  end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage with output + skid register: 1-cycle latency; in_ready is registered
// (!skid_valid) so backpressure never combinationally reaches upstream.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int OPW        = 8,
  parameter int HAS_MULDIV = 1,
  parameter int PCW        = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_inst,
  input  logic [PCW-1:0] in_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_op,
  output logic [4:0]     out_rd,
  output logic [4:0]     out_rj,
  output logic [4:0]     out_rk,
  output logic [31:0]    out_imm,
  output logic [PCW-1:0] out_pc,
  output logic           out_ine
);

  localparam dec_t DEC_RST = '{op: OP_INVALID, ine: 1'b0, imm: 32'b0, rd: 5'b0, rj: 5'b0, rk: 5'b0};

  op_e            dec_op;
  logic [31:0]    dec_imm;
  logic           dec_ine;
  dec_t           dec;
  dec_t           out_q;
  dec_t           skid_q;
  logic [PCW-1:0] out_pc_q;
  logic [PCW-1:0] skid_pc_q;
  logic           skid_valid;
  logic           accept;
  logic           load_out;

  decode_core #(.HAS_MULDIV(HAS_MULDIV)) u_decode_core (
    .inst (in_inst),
    .op   (dec_op),
    .imm  (dec_imm),
    .ine  (dec_ine)
  );

  always_comb begin
    dec = '{op: dec_op, ine: dec_ine, imm: dec_imm,
            rd: in_inst[4:0], rj: in_inst[9:5], rk: in_inst[14:10]};
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign load_out = !out_valid || out_ready;

  // Skid can only be occupied while the output register is stalled, so a
  // draining output takes the skid entry and no new input competes for it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= DEC_RST;
      skid_q     <= DEC_RST;
      out_pc_q   <= '0;
      skid_pc_q  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_q      <= skid_q;
        out_pc_q   <= skid_pc_q;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          out_q    <= dec;
          out_pc_q <= in_pc;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q     <= dec;
      skid_pc_q  <= in_pc;
    end
  end

  assign out_op  = OPW'(out_q.op);
  assign out_rd  = out_q.rd;
  assign out_rj  = out_q.rj;
  assign out_rk  = out_q.rk;
  assign out_imm = out_q.imm;
  assign out_ine = out_q.ine;
  assign out_pc  = out_pc_q;

endmodule

// File: doc/id_decode_stage.md
ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 SHALL have parameter OPW, default 8, width of out_op code.
REQ-002 SHALL have parameter HAS_MULDIV, default 1; 0 makes MUL/DIV/MOD group decode as invalid.
REQ-003 SHALL have parameter PCW, default 32, PC width.
REQ-004 Ports, in this order: clk  in  1  sole clock, rising edge; resetn  in  1  asynchronous, active-low reset.
REQ-005 flush  in  1  discard all held and incoming instructions this cycle.
REQ-006 in_valid  in  1; in_ready  out  1; in_inst  in  32; in_pc  in  PCW: upstream (IF) handshake.
REQ-007 out_valid  out  1; out_ready  in  1: downstream (EX) handshake.
REQ-008 out_op  out  OPW  opcode; out_rd, out_rj, out_rk  out  5  register fields; out_imm  out  32  extended immediate; out_pc  out  PCW; out_ine  out  1  instruction-not-exist flag.

Function
REQ-009 Transfer SHALL occur on a rising edge when valid and ready are both high on that interface.
REQ-010 Latency SHALL be exactly 1 cycle from input accept to out_valid when output stage is empty or draining.
REQ-011 Block SHALL hold two entries: output register plus one skid register; in_ready SHALL equal !skid_valid (registered, no combinational path from out_ready).
REQ-012 Accept while output holds an entry and out_ready=0 SHALL write skid; when output drains, skid SHALL move to output next edge; input accepted same edge SHALL go to skid.
REQ-013 out_* data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-014 Decode on inst[31:15] SHALL cover 3R: ADD.W SUB.W SLT SLTU NOR AND OR XOR SLL.W SRL.W SRA.W MUL.W MULH.W MULH.WU DIV.W MOD.W DIV.WU MOD.WU BREAK SYSCALL; shift-imm: SLLI.W SRLI.W SRAI.W (LA32R encodings).
REQ-015 Decode on inst[31:22] SHALL cover 2RI12: ADDI.W SLTI SLTUI ANDI ORI XORI LD.W ST.W; on inst[31:25] 1RI20: LU12I.W PCADDU12I.
REQ-016 Immediates: si12 sign-extended (ADDI.W SLTI SLTUI LD.W ST.W); ui12 zero-extended (ANDI ORI XORI); ui5 = inst[14:10] zero-extended (shift-imm); {inst[24:5],12'b0} (1RI20); BREAK/SYSCALL code = inst[14:0] zero-extended; 3R imm = 0.
REQ-017 out_rd=inst[4:0], out_rj=inst[9:5], out_rk=inst[14:10] for every format.
REQ-018 Unmatched encodings, or MUL/DIV group when HAS_MULDIV=0, SHALL give out_op=OP_INVALID, out_ine=1, out_imm=0; entry still flows downstream.
REQ-019 flush=1 SHALL clear output and skid valid at the edge; input presented same cycle SHALL be dropped; in_ready SHALL be 1 the following cycle.
REQ-020 flush SHALL take priority over any simultaneous accept or drain.

Reset
REQ-021 resetn=0 SHALL asynchronously clear out_valid, skid_valid, out_op (to OP_INVALID), out_ine, out_rd/rj/rk, out_imm, out_pc to 0 (OP_INVALID as defined).
REQ-022 in_ready SHALL be 1 from the first edge after resetn deasserts; reset mid-transfer SHALL lose all held entries.

Structure
REQ-023 All OP_* codes, including new 2RI12/1RI20 codes and OP_INVALID, SHALL live in the shared defines file; OPW SHALL cover every code.
REQ-024 Combinational decode SHALL be a sub-module decode_core (inst in; op, imm, ine out); id_decode_stage owns handshake and registers.

Verification
REQ-025 in 0x00100C41 (ADD.W r1,r2,r3), out_ready=1 -> next cycle out_valid=1, out_op=OP_ADD, rd=1 rj=2 rk=3, imm=0, ine=0.
REQ-026 in 0x02BFFCA4 (ADDI.W r4,r5,-1) -> out_op=OP_ADDI, rd=4, rj=5, out_imm=0xFFFFFFFF.
REQ-027 HAS_MULDIV=0, in 0x001C0C41 (MUL.W) -> out_op=OP_INVALID, out_ine=1; HAS_MULDIV=1 -> OP_MUL, ine=0.
REQ-028 out_ready=0, three back-to-back in_valid -> first two accepted, in_ready=0 on third; release out_ready -> all three emerge in order, none lost or duplicated.
REQ-029 Output and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing from flush cycle emitted.
REQ-030 resetn pulsed low mid-stream asynchronously -> out_valid=0 immediately, out_op=OP_INVALID, in_ready=1 after release.
